// File: rtl/lz4_pkg.sv
// Shared types and constants for the LZ4 output byte serializer.
// Holds the FSM encoding, the datapath widths and the byte-lane select helper.
package lz4_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StLast,
      StDone
   } lz4_state_e;

   // Byte idx of a word in emission order; msb_first walks lanes 3..0 instead of 0..3.
   function automatic logic [BYTE_W-1:0] lz4_pick_byte(input logic [WORD_W-1:0] word,
                                                       input logic [1:0]        idx,
                                                       input logic              msb_first);
      logic [1:0]        lane;
      logic [BYTE_W-1:0] b;
      lane = msb_first ? (2'd3 - idx) : idx;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lz4_word_buf.sv
// Circular word buffer between the LZ4 output FIFO and the byte emitter.
// Push and pop may coincide; the caller's read credit keeps it from overflowing.
module lz4_word_buf
   import lz4_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WORD_W-1:0]      push_data,
   input  logic                   pop,
   output logic [WORD_W-1:0]      head_data,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W:0]    occ_q;
   logic [PTR_W:0]    occ_d;

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
         2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign occupancy = occ_q;
   assign empty     = (occ_q == '0);

endmodule

// File: rtl/lz4_byte_serializer.sv
// Drains the LZ4 core's 32-bit output FIFO and emits the block as a valid/ready byte stream,
// flagging the final byte and counting accepted bytes.
module lz4_byte_serializer
   import lz4_pkg::*;
#(
   parameter int unsigned BUF_DEPTH  = 2,
   parameter int unsigned BYTE_ORDER = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              lz_out_en,
   input  logic [WORD_W-1:0] lz_out_data,
   input  logic              lz_out_empty,
   input  logic              lz_out_valid,
   input  logic              lz_done,
   input  logic [1:0]        lz_tail_bytes,
   output logic [BYTE_W-1:0] byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last,
   output logic [31:0]       byte_count,
   output logic              frame_done
);

   localparam int unsigned     OCC_W    = $clog2(BUF_DEPTH) + 1;
   localparam logic [OCC_W:0]  CREDITS  = (OCC_W + 1)'(BUF_DEPTH);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(BUF_DEPTH);

   lz4_state_e state_q, state_d;

   logic              in_flight_q;
   logic              done_seen_q;
   logic [1:0]        tail_q;
   logic [1:0]        idx_q;
   logic [31:0]       byte_count_q;

   logic [OCC_W-1:0]  occ;
   logic [OCC_W:0]    credit_used;
   logic [WORD_W-1:0] head_word;
   logic              buf_empty;
   logic              push;
   logic              pop;
   logic              emit;
   logic              accept;
   logic              read_phase;
   logic              last_cond;
   logic              drained;
   logic              is_last_word;
   logic              final_accept;
   logic              block_start;
   logic [1:0]        tail_m1;

   lz4_word_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_word_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (lz_out_data),
      .pop       (pop),
      .head_data (head_word),
      .occupancy (occ),
      .empty     (buf_empty)
   );

   // A read is only issued when a buffer slot is guaranteed for its data next cycle.
   assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, in_flight_q};
   assign read_phase  = (state_q == StIdle) || (state_q == StRun);
   assign lz_out_en   = read_phase && !lz_out_empty && (credit_used < CREDITS);
   assign push        = lz_out_valid && in_flight_q;

   assign emit       = ((state_q == StRun) || (state_q == StLast)) && !buf_empty;
   assign byte_valid = emit;
   assign byte_data  = emit ? lz4_pick_byte(head_word, idx_q, BYTE_ORDER != 0) : '0;
   assign accept     = emit && byte_ready;

   // Tail of 0 means a full final word, so tail-1 wraps to index 3.
   assign tail_m1   = tail_q - 2'd1;
   assign last_cond = done_seen_q && lz_out_empty && !in_flight_q && (occ == OCC_W'(1));
   assign drained   = done_seen_q && lz_out_empty && !in_flight_q && buf_empty;

   // The last word can already be at the head in RUN, before the FSM has moved to LAST.
   assign is_last_word = (state_q == StLast) || ((state_q == StRun) && last_cond);
   assign byte_last    = emit && is_last_word && (idx_q == tail_m1);
   assign final_accept = accept && byte_last;
   assign pop          = accept && ((idx_q == 2'd3) || byte_last);

   assign frame_done = (state_q == StDone);
   assign byte_count = byte_count_q;

   always_comb begin
      state_d     = state_q;
      block_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (push || lz_done) begin
               block_start = 1'b1;
               if (lz_done && !lz_out_valid && !in_flight_q && lz_out_empty && buf_empty) begin
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (final_accept) begin
               state_d = StDone;
            end else if (last_cond) begin
               state_d = StLast;
            end else if (drained) begin
               state_d = StDone;
            end
         end
         StLast: begin
            if (final_accept) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         in_flight_q  <= 1'b0;
         done_seen_q  <= 1'b0;
         tail_q       <= 2'd0;
         idx_q        <= 2'd0;
         byte_count_q <= '0;
      end else begin
         state_q <= state_d;

         if (lz_out_en) begin
            in_flight_q <= 1'b1;
         end else if (lz_out_valid) begin
            in_flight_q <= 1'b0;
         end

         if (pop) begin
            idx_q <= 2'd0;
         end else if (accept) begin
            idx_q <= idx_q + 2'd1;
         end

         // Only the first lz_done of a block is honoured.
         if (state_q == StDone) begin
            done_seen_q <= 1'b0;
         end else if (lz_done && !done_seen_q) begin
            done_seen_q <= 1'b1;
            tail_q      <= lz_tail_bytes;
         end

         if (block_start) begin
            byte_count_q <= '0;
         end else if (accept) begin
            byte_count_q <= byte_count_q + 32'd1;
         end
      end
   end

   a_no_orphan_valid : assert property (@(posedge clk) disable iff (rst)
      lz_out_valid |-> in_flight_q);

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (push && !pop) |-> (occ != FULL_OCC));

endmodule

// File: tb/tb_lz4_byte_serializer.sv
// Scoreboard bench for lz4_byte_serializer: a FIFO model feeds words, expected bytes are
// queued at load time and retired as the DUT hands bytes over.
module tb_lz4_byte_serializer;

   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       eow;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        lz_out_en, lz_out_empty, lz_out_valid, lz_done;
   logic [31:0] lz_out_data;
   logic [1:0]  lz_tail_bytes;
   logic [7:0]  byte_data;
   logic        byte_valid, byte_ready, byte_last, frame_done;
   logic [31:0] byte_count;

   logic        lz_out_en1, lz_out_empty1, lz_out_valid1, lz_done1;
   logic [31:0] lz_out_data1;
   logic [1:0]  lz_tail_bytes1;
   logic [7:0]  byte_data1;
   logic        byte_valid1, byte_ready1, byte_last1, frame_done1;
   logic [31:0] byte_count1;

   lz4_byte_serializer #(
      .BUF_DEPTH  (DEPTH),
      .BYTE_ORDER (0)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .lz_out_en     (lz_out_en),
      .lz_out_data   (lz_out_data),
      .lz_out_empty  (lz_out_empty),
      .lz_out_valid  (lz_out_valid),
      .lz_done       (lz_done),
      .lz_tail_bytes (lz_tail_bytes),
      .byte_data     (byte_data),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .byte_last     (byte_last),
      .byte_count    (byte_count),
      .frame_done    (frame_done)
   );

   lz4_byte_serializer #(
      .BUF_DEPTH  (DEPTH),
      .BYTE_ORDER (1)
   ) u_dut_msb (
      .clk           (clk),
      .rst           (rst),
      .lz_out_en     (lz_out_en1),
      .lz_out_data   (lz_out_data1),
      .lz_out_empty  (lz_out_empty1),
      .lz_out_valid  (lz_out_valid1),
      .lz_done       (lz_done1),
      .lz_tail_bytes (lz_tail_bytes1),
      .byte_data     (byte_data1),
      .byte_valid    (byte_valid1),
      .byte_ready    (byte_ready1),
      .byte_last     (byte_last1),
      .byte_count    (byte_count1),
      .frame_done    (frame_done1)
   );

   exp_t        exp_q[$];
   exp_t        exp1_q[$];
   logic [31:0] fifo_mem [256];
   int          fifo_wr, fifo_rd;
   logic        pend_valid, pend1_valid, w1_full;
   logic [31:0] pend_data, w1;
   int          vectors, miscompares;
   int          tb_occ, accepted, cyc, last_accept_cyc, frame_cyc;
   bit          frame_seen, frame1_seen;
   logic        drv_rst, drv_done, drv_done1, rand_ready;
   logic [1:0]  drv_tail;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      rst            = drv_rst;
      lz_done        = drv_done;
      lz_tail_bytes  = drv_tail;
      lz_out_empty   = (fifo_wr == fifo_rd);
      lz_out_valid   = pend_valid;
      lz_out_data    = pend_data;
      byte_ready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      lz_done1       = drv_done1;
      lz_tail_bytes1 = 2'd0;
      lz_out_empty1  = !w1_full;
      lz_out_valid1  = pend1_valid;
      lz_out_data1   = w1;
      byte_ready1    = 1'b1;
      #1;
      if (drv_rst) begin
         exp_q.delete();
         exp1_q.delete();
         fifo_rd     = fifo_wr;
         pend_valid  = 1'b0;
         pend1_valid = 1'b0;
         w1_full     = 1'b0;
         tb_occ      = 0;
         return;
      end
      if (lz_out_en) begin
         check_eq("en_while_empty", lz_out_empty, 1'b0);
         check_eq("read_credit", 32'((tb_occ + int'(pend_valid)) < int'(DEPTH)), 1);
      end
      if (byte_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_valid", byte_valid, 1'b0);
         end else begin
            e = exp_q[0];
            check_eq("byte_data", byte_data, e.data);
            check_eq("byte_last", byte_last, e.last);
            if (byte_ready) begin
               void'(exp_q.pop_front());
               accepted++;
               last_accept_cyc = cyc;
               if (e.eow) tb_occ--;
            end
         end
      end
      if (frame_done) begin
         frame_seen = 1'b1;
         frame_cyc  = cyc;
      end
      if (pend_valid) tb_occ++;
      pend_valid = 1'b0;
      if (lz_out_en && (fifo_wr != fifo_rd)) begin
         pend_valid = 1'b1;
         pend_data  = fifo_mem[fifo_rd % 256];
         fifo_rd++;
      end
      // Second instance: single-word source, always-ready sink.
      if (lz_out_en1) check_eq("msb_en_while_empty", lz_out_empty1, 1'b0);
      if (byte_valid1) begin
         if (exp1_q.size() == 0) begin
            check_eq("msb_spurious_valid", byte_valid1, 1'b0);
         end else begin
            e = exp1_q.pop_front();
            check_eq("msb_byte_data", byte_data1, e.data);
            check_eq("msb_byte_last", byte_last1, e.last);
         end
      end
      if (frame_done1) frame1_seen = 1'b1;
      pend1_valid = 1'b0;
      if (lz_out_en1 && w1_full) begin
         pend1_valid = 1'b1;
         w1_full     = 1'b0;
      end
   endtask

   task automatic load_word(input logic [31:0] w, input int nbytes);
      exp_t e;
      fifo_mem[fifo_wr % 256] = w;
      fifo_wr++;
      for (int i = 0; i < nbytes; i++) begin
         e.data = w[8*i +: 8];
         e.last = 1'b0;
         e.eow  = (i == nbytes - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic end_block(input logic [1:0] tail);
      exp_q[exp_q.size() - 1].last = 1'b1;
      drv_tail = tail;
      drv_done = 1'b1;
      tick();
      drv_done = 1'b0;
   endtask

   task automatic wait_frame(input int budget, input string tag);
      frame_seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (frame_seen) break;
      end
      check_eq({tag, "_frame_done_seen"}, frame_seen, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_lz_out_en"}, lz_out_en, 1'b0);
      check_eq({tag, "_byte_valid"}, byte_valid, 1'b0);
      check_eq({tag, "_byte_last"}, byte_last, 1'b0);
      check_eq({tag, "_byte_data"}, byte_data, 8'h00);
      check_eq({tag, "_byte_count"}, byte_count, 32'd0);
      check_eq({tag, "_frame_done"}, frame_done, 1'b0);
   endtask

   task automatic run_block(input string tag, input logic [1:0] tail, input int nbytes);
      int a0;
      a0 = accepted;
      end_block(tail);
      wait_frame(3000, tag);
      check_eq({tag, "_byte_count"}, byte_count, nbytes);
      check_eq({tag, "_bytes_accepted"}, accepted - a0, nbytes);
      check_eq({tag, "_frame_delay"}, frame_cyc - last_accept_cyc, 1);
      check_eq({tag, "_left_over"}, exp_q.size(), 0);
      tick();
      check_eq({tag, "_frame_pulse_width"}, frame_done, 1'b0);
      tick();
   endtask

   initial begin
      int a0;
      exp_t e;
      vectors = 0; miscompares = 0; fifo_wr = 0; fifo_rd = 0; tb_occ = 0;
      accepted = 0; cyc = 0; last_accept_cyc = 0; frame_cyc = 0;
      frame_seen = 1'b0; frame1_seen = 1'b0;
      pend_valid = 1'b0; pend1_valid = 1'b0; w1_full = 1'b0;
      pend_data = '0; w1 = '0;
      drv_rst = 1'b1; drv_done = 1'b0; drv_done1 = 1'b0; drv_tail = 2'd0; rand_ready = 1'b0;
      rst = 1'b1; lz_done = 1'b0; lz_tail_bytes = '0; lz_out_empty = 1'b1; lz_out_valid = 1'b0;
      lz_out_data = '0; byte_ready = 1'b1;
      lz_done1 = 1'b0; lz_tail_bytes1 = '0; lz_out_empty1 = 1'b1; lz_out_valid1 = 1'b0;
      lz_out_data1 = '0; byte_ready1 = 1'b1;

      repeat (3) tick();
      drv_rst = 1'b0;
      tick();
      check_reset_vals("reset");

      // Full final word.
      load_word(32'h44332211, 4);
      load_word(32'h88776655, 4);
      run_block("full_tail", 2'd0, 8);

      // Two-byte final word.
      load_word(32'h44332211, 4);
      load_word(32'h88776655, 2);
      run_block("tail2", 2'd2, 6);

      // Random backpressure across 64 words.
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) load_word($urandom, 4);
      run_block("backpressure", 2'd0, 256);
      rand_ready = 1'b0;

      // Empty block: nothing ever read.
      drv_done = 1'b1;
      tick();
      drv_done = 1'b0;
      wait_frame(10, "empty");
      check_eq("empty_byte_count", byte_count, 32'd0);
      check_eq("empty_byte_last", byte_last, 1'b0);
      tick();
      tick();

      // Reset while the head word sits at byte index 2.
      load_word(32'h0D0C0B0A, 4);
      exp_q[exp_q.size() - 1].last = 1'b1;
      drv_done = 1'b1;
      tick();
      drv_done = 1'b0;
      a0 = accepted;
      for (int i = 0; i < 50; i++) begin
         if (accepted - a0 >= 2) break;
         tick();
      end
      check_eq("midword_accepted", accepted - a0, 2);
      drv_rst = 1'b1;
      tick();
      drv_rst = 1'b0;
      tick();
      check_reset_vals("midword_reset");
      load_word(32'h44332211, 4);
      run_block("after_reset", 2'd0, 4);

      // MSB-first instance.
      w1      = 32'hAABBCCDD;
      w1_full = 1'b1;
      e.eow = 1'b0;
      e.last = 1'b0; e.data = 8'hAA; exp1_q.push_back(e);
      e.data = 8'hBB; exp1_q.push_back(e);
      e.data = 8'hCC; exp1_q.push_back(e);
      e.last = 1'b1; e.data = 8'hDD; exp1_q.push_back(e);
      frame1_seen = 1'b0;
      drv_done1   = 1'b1;
      tick();
      drv_done1 = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (frame1_seen) break;
         tick();
      end
      check_eq("msb_frame_done_seen", frame1_seen, 1'b1);
      check_eq("msb_left_over", exp1_q.size(), 0);
      check_eq("msb_byte_count", byte_count1, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
